// File: rtl/stopwatch_seq.sv
// Stopwatch sequencer: press classifier, run/lap/pause FSM,
// 1 s prescaler, BCD mm:ss counter and lap-frozen display.
module stopwatch_seq #(
  parameter int TICKS_PER_SEC = 100,
  parameter int LONG_PRESS    = 100
) (
  input  logic        clk_100,
  input  logic        rst_n,
  input  logic        de_start_stop,
  input  logic        lap_reset_lvl,
  output logic        count_enable,
  output logic        lap_enable,
  output logic        clr,
  output logic        sec_tick,
  output logic [15:0] live_bcd,
  output logic [15:0] disp_bcd
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int HW = $clog2(LONG_PRESS + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [HW-1:0] HLONG = HW'(LONG_PRESS - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE
  } state_e;

  state_e        r_state;
  state_e        w_nxt;
  logic          r_lvl_q;
  logic          r_armed;
  logic [HW-1:0] r_hold;
  logic          r_short;
  logic          r_long;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre;
  logic [15:0]   w_live;
  logic          w_clear;
  logic          w_wrap;
  logic          w_rise;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) begin
      r[3:0] = v[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd5) begin
        r[7:4] = v[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) begin
          r[11:8] = v[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = (v[15:12] == 4'd5) ? 4'd0
                                        : v[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign w_rise = lap_reset_lvl & ~r_lvl_q;

  // r_lvl_q resets high so a button held through reset is not a press
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_lvl_q <= 1'b1;
      r_armed <= 1'b0;
      r_hold  <= '0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_lvl_q <= lap_reset_lvl;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      if (w_rise) begin
        r_armed <= 1'b1;
        r_hold  <= '0;
      end else if (lap_reset_lvl) begin
        if (r_hold != {HW{1'b1}})
          r_hold <= r_hold + HW'(1);
        if (r_armed && r_hold == HLONG) begin
          r_long  <= 1'b1;
          r_armed <= 1'b0;
        end
      end else if (r_armed) begin
        r_short <= 1'b1;
        r_armed <= 1'b0;
      end
    end
  end

  always_comb begin
    w_nxt   = r_state;
    w_clear = 1'b0;
    if (r_long) begin
      w_nxt   = S_IDLE;
      w_clear = 1'b1;
    end else if (de_start_stop) begin
      w_nxt = (r_state == S_RUN || r_state == S_LAP) ? S_PAUSE
                                                     : S_RUN;
    end else if (r_short) begin
      unique case (r_state)
        S_IDLE:  w_nxt = S_IDLE;
        S_RUN:   w_nxt = S_LAP;
        S_LAP:   w_nxt = S_RUN;
        S_PAUSE: begin
          w_nxt   = S_IDLE;
          w_clear = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_wrap = count_enable && (r_pre == PMAX);
    w_pre  = r_pre;
    w_live = live_bcd;
    if (w_clear) begin
      w_pre  = '0;
      w_live = '0;
    end else if (count_enable) begin
      if (w_wrap) begin
        w_pre  = '0;
        w_live = bcd_inc(live_bcd);
      end else begin
        w_pre = r_pre + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pre        <= '0;
      live_bcd     <= '0;
      disp_bcd     <= '0;
      count_enable <= 1'b0;
      lap_enable   <= 1'b0;
      clr          <= 1'b0;
      sec_tick     <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_pre        <= w_pre;
      live_bcd     <= w_live;
      count_enable <= (w_nxt == S_RUN) || (w_nxt == S_LAP);
      lap_enable   <= (w_nxt == S_LAP);
      clr          <= w_clear;
      sec_tick     <= w_wrap && !w_clear;
      // display freezes only while staying in LAP
      if (!(r_state == S_LAP && w_nxt == S_LAP))
        disp_bcd <= w_live;
    end
  end

endmodule

// File: tb/tb_stopwatch_seq.sv
// Bench for stopwatch_seq: cycle model check plus directed
// scenarios; a fast-prescaler instance covers the 59:59 wrap.
module tb_stopwatch_seq;

  localparam int T = 100;
  localparam int L = 100;

  logic        clk_100;
  logic        rst_n;
  logic        de_start_stop;
  logic        lap_reset_lvl;
  logic        count_enable;
  logic        lap_enable;
  logic        clr;
  logic        sec_tick;
  logic [15:0] live_bcd;
  logic [15:0] disp_bcd;

  logic        ss2;
  logic        lvl2;
  logic        ce2;
  logic        le2;
  logic        clr2;
  logic        tick2;
  logic [15:0] live2;
  logic [15:0] disp2;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  stopwatch_seq #(.TICKS_PER_SEC(T), .LONG_PRESS(L)) dut (
    .clk_100(clk_100),
    .rst_n(rst_n),
    .de_start_stop(de_start_stop),
    .lap_reset_lvl(lap_reset_lvl),
    .count_enable(count_enable),
    .lap_enable(lap_enable),
    .clr(clr),
    .sec_tick(sec_tick),
    .live_bcd(live_bcd),
    .disp_bcd(disp_bcd)
  );

  stopwatch_seq #(.TICKS_PER_SEC(2), .LONG_PRESS(4)) dut2 (
    .clk_100(clk_100),
    .rst_n(rst_n),
    .de_start_stop(ss2),
    .lap_reset_lvl(lvl2),
    .count_enable(ce2),
    .lap_enable(le2),
    .clr(clr2),
    .sec_tick(tick2),
    .live_bcd(live2),
    .disp_bcd(disp2)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  // behavioural model: seconds as an integer, presses as timestamps
  typedef enum int {M_IDLE, M_RUN, M_LAP, M_PAUSE} mst_e;
  mst_e m_st = M_IDLE;
  int m_pre = 0, m_sec = 0, m_dsec = 0;
  bit m_ce = 0, m_le = 0, m_clr = 0, m_tick = 0;
  int m_n = 0, m_start = 0, m_short_at = -1, m_long_at = -1;
  bit m_prev = 1, m_armed = 0;

  task automatic model_step();
    bit ev_l, ev_s, clear;
    mst_e cur, nxt;
    if (!rst_n) begin
      m_st = M_IDLE; m_pre = 0; m_sec = 0; m_dsec = 0;
      m_ce = 0; m_le = 0; m_clr = 0; m_tick = 0;
      m_prev = 1; m_armed = 0; m_short_at = -1; m_long_at = -1;
      return;
    end
    m_n++;
    ev_l = (m_n == m_long_at);
    ev_s = (m_n == m_short_at);
    if (lap_reset_lvl && !m_prev) begin
      m_start = m_n;
      m_armed = 1;
    end else if (m_armed && lap_reset_lvl && m_n - m_start == L - 1) begin
      m_long_at = m_n + 1;
      m_armed = 0;
    end else if (m_armed && !lap_reset_lvl) begin
      m_short_at = m_n + 1;
      m_armed = 0;
    end
    m_prev = lap_reset_lvl;
    cur = m_st;
    nxt = cur;
    clear = 0;
    if (ev_l) begin
      nxt = M_IDLE;
      clear = 1;
    end else if (de_start_stop) begin
      nxt = (cur == M_RUN || cur == M_LAP) ? M_PAUSE : M_RUN;
    end else if (ev_s) begin
      if (cur == M_RUN) nxt = M_LAP;
      else if (cur == M_LAP) nxt = M_RUN;
      else if (cur == M_PAUSE) begin
        nxt = M_IDLE;
        clear = 1;
      end
    end
    m_tick = 0;
    if (clear) begin
      m_pre = 0;
      m_sec = 0;
    end else if (m_ce) begin
      m_pre++;
      if (m_pre == T) begin
        m_pre = 0;
        m_sec = (m_sec + 1) % 3600;
        m_tick = 1;
      end
    end
    if (!(cur == M_LAP && nxt == M_LAP)) m_dsec = m_sec;
    m_st = nxt;
    m_ce = (nxt == M_RUN || nxt == M_LAP);
    m_le = (nxt == M_LAP);
    m_clr = clear;
  endtask

  initial forever begin
    @(posedge clk_100 or negedge rst_n);
    model_step();
  end

  always @(negedge clk_100) begin
    if (cmp_en) begin
      chk1("m_count_enable", count_enable, m_ce);
      chk1("m_lap_enable", lap_enable, m_le);
      chk1("m_clr", clr, m_clr);
      chk1("m_sec_tick", sec_tick, m_tick);
      chk16("m_live_bcd", live_bcd, to_bcd(m_sec));
      chk16("m_disp_bcd", disp_bcd, to_bcd(m_dsec));
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk_100);
    #1;
  endtask

  task automatic pulse_ss();
    de_start_stop = 1'b1;
    tick_n(1);
    de_start_stop = 1'b0;
  endtask

  task automatic short_press(input int n);
    lap_reset_lvl = 1'b1;
    tick_n(n);
    lap_reset_lvl = 1'b0;
    tick_n(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick_n(2);
    rst_n = 1'b1;
    tick_n(2);
  endtask

  initial begin
    rst_n = 1'b0;
    de_start_stop = 1'b0;
    lap_reset_lvl = 1'b0;
    ss2 = 1'b0;
    lvl2 = 1'b0;
    tick_n(3);
    cmp_en = 1;
    chk1("rst_count_enable", count_enable, 1'b0);
    chk16("rst_live", live_bcd, 16'h0000);
    chk16("rst_disp", disp_bcd, 16'h0000);
    rst_n = 1'b1;
    tick_n(2);

    // first second
    pulse_ss();
    chk1("run_ce_after_pulse", count_enable, 1'b1);
    tick_n(99);
    chk16("live_before_1s", live_bcd, 16'h0000);
    chk1("no_tick_99", sec_tick, 1'b0);
    tick_n(1);
    chk16("live_at_1s", live_bcd, 16'h0001);
    chk1("tick_at_100", sec_tick, 1'b1);
    tick_n(1);
    chk1("tick_one_cycle", sec_tick, 1'b0);

    // lap freeze at 00:05
    tick_n(399);
    chk16("live_005", live_bcd, 16'h0005);
    short_press(10);
    chk1("lap_entered", lap_enable, 1'b1);
    chk16("lap_disp_005", disp_bcd, 16'h0005);
    tick_n(288);
    chk16("lap_live_008", live_bcd, 16'h0008);
    chk16("lap_disp_frozen", disp_bcd, 16'h0005);
    short_press(10);
    chk1("lap_exit", lap_enable, 1'b0);
    chk16("lap_exit_disp", disp_bcd, 16'h0008);

    // pause with prescaler at 40, resume, clear from pause
    do_reset();
    pulse_ss();
    tick_n(339);
    pulse_ss();
    chk1("pause_ce", count_enable, 1'b0);
    chk16("pause_live_003", live_bcd, 16'h0003);
    tick_n(50);
    chk16("pause_hold_003", live_bcd, 16'h0003);
    pulse_ss();
    tick_n(59);
    chk16("resume_59", live_bcd, 16'h0003);
    tick_n(1);
    chk16("resume_60", live_bcd, 16'h0004);
    chk1("resume_tick", sec_tick, 1'b1);
    pulse_ss();
    short_press(5);
    chk1("pause_short_clr", clr, 1'b1);
    chk16("pause_short_live", live_bcd, 16'h0000);
    chk1("pause_short_ce", count_enable, 1'b0);
    tick_n(1);
    chk1("clr_one_cycle", clr, 1'b0);

    // long press from RUN
    pulse_ss();
    tick_n(20);
    lap_reset_lvl = 1'b1;
    tick_n(100);
    chk1("long_pre_clr", clr, 1'b0);
    chk1("long_pre_ce", count_enable, 1'b1);
    tick_n(1);
    chk1("long_clr", clr, 1'b1);
    chk1("long_ce", count_enable, 1'b0);
    chk16("long_live", live_bcd, 16'h0000);
    tick_n(49);
    lap_reset_lvl = 1'b0;
    tick_n(3);
    chk1("long_release_clr", clr, 1'b0);
    chk1("long_release_le", lap_enable, 1'b0);

    // start/stop coincides with short event
    pulse_ss();
    tick_n(30);
    lap_reset_lvl = 1'b1;
    tick_n(10);
    lap_reset_lvl = 1'b0;
    tick_n(1);
    de_start_stop = 1'b1;
    tick_n(1);
    de_start_stop = 1'b0;
    chk1("coinc_ce", count_enable, 1'b0);
    chk1("coinc_le", lap_enable, 1'b0);
    tick_n(2);
    chk1("coinc_le_later", lap_enable, 1'b0);

    // async reset mid-count, button held through release
    pulse_ss();
    tick_n(150);
    chk1("pre_rst_ce", count_enable, 1'b1);
    rst_n = 1'b0;
    lap_reset_lvl = 1'b1;
    #1;
    chk1("arst_ce", count_enable, 1'b0);
    chk1("arst_le", lap_enable, 1'b0);
    chk1("arst_clr", clr, 1'b0);
    chk1("arst_tick", sec_tick, 1'b0);
    chk16("arst_live", live_bcd, 16'h0000);
    chk16("arst_disp", disp_bcd, 16'h0000);
    tick_n(2);
    rst_n = 1'b1;
    tick_n(2);
    pulse_ss();
    tick_n(150);
    chk1("held_no_long", count_enable, 1'b1);
    lap_reset_lvl = 1'b0;
    tick_n(3);
    chk1("held_no_short", lap_enable, 1'b0);
    cmp_en = 0;

    // full-range wrap on the fast instance
    ss2 = 1'b1;
    tick_n(1);
    ss2 = 1'b0;
    for (int c = 1; c <= 7205; c++) begin
      tick_n(1);
      chk16("wrap_live", live2, to_bcd((c / 2) % 3600));
      chk16("wrap_disp", disp2, live2);
      chk1("wrap_tick", tick2, (c % 2) == 0);
      chk1("wrap_digits", live2[3:0] <= 4'd9 && live2[7:4] <= 4'd5 &&
           live2[11:8] <= 4'd9 && live2[15:12] <= 4'd5, 1'b1);
      if (c == 7196) chk16("wrap_5958", live2, 16'h5958);
      if (c == 7198) chk16("wrap_5959", live2, 16'h5959);
      if (c == 7200) chk16("wrap_0000", live2, 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_seq.md
# stopwatch_seq

Sequencer and time base for the lab-7 stopwatch. It takes the debounced start/stop pulse and the debounced lap/reset button level, and classifies lap/reset presses as short or long. It runs the RUN/PAUSE/LAP/IDLE state machine, divides clk_100 into a 1 s tick, and drives the BCD mm:ss counter and the lap-frozen display registers. It sits between the debounce/one-pulse stage and the seven-segment driver.

## Interface
- TICKS_PER_SEC, default 100: clk_100 cycles per counted second.
- LONG_PRESS, default 100: hold cycles that classify a lap/reset press as long (1 s).
- clk_100  input  1  system clock (100 Hz).
- rst_n  input  1  reset, asynchronous, active-low.
- de_start_stop  input  1  one-cycle pulse per start/stop press.
- lap_reset_lvl  input  1  debounced lap/reset button level, 1 = held.
- count_enable  output  1  registered; high in RUN and LAP.
- lap_enable  output  1  registered; high in LAP (display frozen).
- clr  output  1  one-cycle registered pulse whenever the time is cleared.
- sec_tick  output  1  one-cycle registered pulse on each counted second.
- live_bcd  output  16  running time {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- disp_bcd  output  16  displayed time; follows live_bcd except in LAP.

## Operation
- Press classifier:
  - A rising edge of lap_reset_lvl starts the hold counter.
  - If the counter reaches LONG_PRESS-1 while the button is still held, one long event fires. The release that follows produces nothing.
  - If the button is released before that point, one short event fires on the release edge.
  - The hold counter saturates and never wraps.
- States and outputs:
  - IDLE: count_enable=0, lap_enable=0.
  - RUN: count_enable=1, lap_enable=0.
  - LAP: count_enable=1, lap_enable=1.
  - PAUSE: count_enable=0, lap_enable=0.
- Transitions, priority long > start_stop > short:
  - IDLE: start_stop → RUN. Short → IDLE, no clr.
  - RUN: start_stop → PAUSE. Short → LAP.
  - LAP: short → RUN. start_stop → PAUSE; the lap freeze is released.
  - PAUSE: start_stop → RUN. Short → IDLE with clear.
  - Any state: long → IDLE with clear.
- Clear action: prescaler and live_bcd go to 0 on the event edge. clr is high for the following cycle.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only while count_enable=1.
  - Holds its value in PAUSE; it is not zeroed.
  - On wrap, live_bcd increments on the same edge.
- BCD arithmetic:
  - sec_ones 0-9 carries into sec_tens 0-5, which carries into min_ones 0-9, which carries into min_tens 0-5.
  - 59:59 + 1 → 00:00 with no stop or flag.
  - Digits never hold a value above 9.
- Display:
  - disp_bcd is loaded with live_bcd every cycle while next state ≠ LAP.
  - On entry to LAP it holds the value captured at the entry edge.
  - On LAP → RUN or LAP → PAUSE it resumes tracking on the exit edge.
- Reset (rst_n=0, any time, including mid-press or mid-count):
  - State IDLE; all outputs 0; live_bcd = disp_bcd = 16'h0000.
  - Prescaler and hold counter cleared.
  - A button held through reset release does not produce an event until it is released and pressed again.

## Timing
- State change takes effect on the clock edge on which de_start_stop is high. count_enable/lap_enable are registered and reflect the new state in the next cycle.
- Short event is asserted in the cycle after the falling edge of lap_reset_lvl is sampled. The state changes on the next edge.
- Long event fires exactly LONG_PRESS cycles after the rising edge is sampled.
- First increment after RUN entry from a zeroed prescaler occurs TICKS_PER_SEC cycles after count_enable goes high.
- sec_tick is high in the same cycle the new live_bcd value is visible.
- Simultaneous start_stop and short in RUN: PAUSE is taken and the short event is dropped.
- Simultaneous start_stop and long: IDLE with clear.

## Test plan
- Reset, then one de_start_stop pulse, then run 100 cycles:
  - count_enable=1 one cycle after the pulse.
  - live_bcd=16'h0001 and sec_tick pulses once at cycle 100.
- Preload to 59:58 via run, then 200 more cycles: live_bcd goes 16'h5959 → 16'h0000 with no glitch digit above 9.
- RUN at 00:05, short press 10 cycles:
  - LAP entered, lap_enable=1.
  - disp_bcd stays 16'h0005 while live_bcd reaches 16'h0008.
  - A second short press gives disp_bcd = live_bcd on the exit edge.
- RUN, start_stop → PAUSE at 00:03 with prescaler at 40:
  - Resume: next increment after 60 cycles.
  - A short press while paused gives clr pulse, IDLE, live_bcd=16'h0000.
- RUN, hold lap_reset_lvl for 150 cycles: clr pulses once at hold cycle 100, state is IDLE, and no short event on release.
- RUN, de_start_stop in the same cycle as a short-event release: state is PAUSE and lap_enable stays 0. Assert rst_n low mid-count: all outputs 0 immediately.
